quadrature_gen: RTL and testbench

Programmable two-phase quadrature pulse generator and the transmit-side counterpart of the on-chip quadrature encoder readers. It is mapped as a responder on the PicoSoC iomem peripheral bus. Firmware sets step period, direction and step count, and the block emits A/B phase signals that can drive the `encoder` inputs for hardware-in-the-loop motor emulation. It also keeps a signed count of emitted steps for cross-checking against the reader.

---
 rtl/quadrature_gen_pkg.sv | 56 +++++
 rtl/quad_phase_fsm.sv | 68 ++++++
 rtl/quadrature_gen.sv | 149 ++++++++++++++
 tb/tb_quadrature_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/quadrature_gen_pkg.sv
// quadrature_gen_pkg
//   Shared definitions for the quadrature pulse generator: register offsets
//   within the iomem page, CTRL bit positions, the two-bit phase encoding and
//   small helpers used by both the top level and the phase FSM.
package quadrature_gen_pkg;

  // Register offsets (iomem_addr[7:0])
  localparam logic [7:0] REG_CTRL     = 8'h00;
  localparam logic [7:0] REG_PERIOD   = 8'h04;
  localparam logic [7:0] REG_STEPS    = 8'h08;
  localparam logic [7:0] REG_POSITION = 8'h0C;

  // CTRL bit indices
  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_DIR_BIT     = 1;
  localparam int CTRL_COUNTED_BIT = 2;
  localparam int CTRL_DONE_BIT    = 8;

  // Shortest usable step period in clocks
  localparam logic [31:0] MIN_PERIOD = 32'd2;

  // Phase encoding is {A,B}, so the state register bits drive the pins
  // directly and only one bit differs between neighbouring states.
  typedef enum logic [1:0] {
    P0 = 2'b00,
    P1 = 2'b10,
    P2 = 2'b11,
    P3 = 2'b01
  } phase_t;

  // Next phase for one step; dir=0 walks P0->P1->P2->P3, dir=1 walks back.
  function automatic phase_t next_phase(input phase_t cur, input logic dir);
    phase_t nxt;
    case (cur)
      P0:      nxt = dir ? P3 : P1;
      P1:      nxt = dir ? P0 : P2;
      P2:      nxt = dir ? P1 : P3;
      P3:      nxt = dir ? P2 : P0;
      default: nxt = P0;
    endcase
    return nxt;
  endfunction

  // Merge a bus write into an existing word honouring the byte strobes.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/quad_phase_fsm.sv
// quad_phase_fsm
//   Step timer plus A/B phase state machine.
//   Ports:
//     clk, resetn : clock, asynchronous active-low reset
//     step_en     : run request (timer frozen and phase held while low)
//     dir         : 0 = forward, 1 = reverse, used for the step being taken
//     period      : clocks per step, values below 2 behave as 2
//     step        : high in the cycle whose closing edge advances the phase
//     enc_a/enc_b : registered phase outputs
module quad_phase_fsm
  import quadrature_gen_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        step_en,
  input  logic        dir,
  input  logic [31:0] period,
  output logic        step,
  output logic        enc_a,
  output logic        enc_b
);

  phase_t      phase;
  phase_t      phase_next;
  logic [31:0] cnt;
  logic [31:0] cnt_next;
  logic        en_d;
  logic [31:0] reload;

  assign reload = ((period < MIN_PERIOD) ? MIN_PERIOD : period) - 32'd1;

  // en_d distinguishes the first enabled cycle, so no step can happen on it.
  assign step  = step_en && en_d && (cnt == 32'd0);
  assign enc_a = phase[1];
  assign enc_b = phase[0];

  // State register for the phase, timer and enable history.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase <= P0;
      cnt   <= 32'd0;
      en_d  <= 1'b0;
    end else begin
      phase <= phase_next;
      cnt   <= cnt_next;
      en_d  <= step_en;
    end
  end

  // Next-state logic. The timer is conceptually loaded with reload on the
  // edge that sets EN; since EN is only seen one cycle later, the first
  // enabled cycle takes the already-decremented value reload-1.
  always_comb begin
    phase_next = phase;
    cnt_next   = cnt;
    if (step_en) begin
      if (!en_d) begin
        cnt_next = reload - 32'd1;
      end else if (cnt == 32'd0) begin
        cnt_next   = reload;
        phase_next = next_phase(phase, dir);
      end else begin
        cnt_next = cnt - 32'd1;
      end
    end
  end

endmodule

// File: rtl/quadrature_gen.sv
// quadrature_gen
//   Programmable quadrature pulse generator on the PicoSoC iomem bus.
//   Ports:
//     clk, resetn          : clock, asynchronous active-low reset
//     iomem_valid/ready    : request / one-cycle acknowledge
//     iomem_wstrb          : byte strobes, 0 = read
//     iomem_addr/wdata     : byte address / write data
//     iomem_rdata          : read data, valid while iomem_ready is high
//     enc_a, enc_b         : quadrature phase outputs
//     done_pulse           : one-cycle pulse when a counted run finishes
module quadrature_gen
  import quadrature_gen_pkg::*;
#(
  parameter logic [23:0] BASE_PAGE      = 24'h03000A,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd1600
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        enc_a,
  output logic        enc_b,
  output logic        done_pulse
);

  logic        ctrl_en;
  logic        ctrl_dir;
  logic        ctrl_counted;
  logic        ctrl_done;
  logic [31:0] period;
  logic [31:0] steps;
  logic [31:0] position;

  logic        take;
  logic        wr;
  logic [7:0]  offset;
  logic        steps_wr;
  logic        pos_wr;
  logic        step_en;
  logic        step;
  logic        zero_start;
  logic        run_done;
  logic [31:0] rd_word;

  assign offset   = iomem_addr[7:0];
  assign take     = iomem_valid && !iomem_ready && (iomem_addr[31:8] == BASE_PAGE);
  assign wr       = take && (iomem_wstrb != 4'b0000);
  assign steps_wr = wr && (offset == REG_STEPS);
  assign pos_wr   = wr && (offset == REG_POSITION);

  // In counted mode an exhausted STEPS count blocks stepping altogether.
  assign step_en    = ctrl_en && !(ctrl_counted && (steps == 32'd0));
  // Enabled counted run with nothing left to do: finish without stepping.
  assign zero_start = ctrl_en && ctrl_counted && (steps == 32'd0) && !steps_wr;
  assign run_done   = (step && ctrl_counted && (steps == 32'd1) && !steps_wr) || zero_start;

  quad_phase_fsm u_phase (
    .clk     (clk),
    .resetn  (resetn),
    .step_en (step_en),
    .dir     (ctrl_dir),
    .period  (period),
    .step    (step),
    .enc_a   (enc_a),
    .enc_b   (enc_b)
  );

  // Read multiplexer; unmapped offsets read as zero.
  always_comb begin
    rd_word = 32'd0;
    case (offset)
      REG_CTRL: begin
        rd_word[CTRL_EN_BIT]      = ctrl_en;
        rd_word[CTRL_DIR_BIT]     = ctrl_dir;
        rd_word[CTRL_COUNTED_BIT] = ctrl_counted;
        rd_word[CTRL_DONE_BIT]    = ctrl_done;
      end
      REG_PERIOD:   rd_word = period;
      REG_STEPS:    rd_word = steps;
      REG_POSITION: rd_word = position;
      default:      rd_word = 32'd0;
    endcase
  end

  // Bus acknowledge and registered read data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'd0;
    end else begin
      iomem_ready <= take;
      iomem_rdata <= take ? rd_word : 32'd0;
    end
  end

  // Register file with step bookkeeping. A bus write to STEPS or POSITION
  // overrides the update from a coincident step. Run completion is applied
  // after any CTRL write so a finished run always halts.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_en      <= 1'b0;
      ctrl_dir     <= 1'b0;
      ctrl_counted <= 1'b0;
      ctrl_done    <= 1'b0;
      period       <= DEFAULT_PERIOD;
      steps        <= 32'd0;
      position     <= 32'd0;
      done_pulse   <= 1'b0;
    end else begin
      done_pulse <= 1'b0;

      if (wr && (offset == REG_CTRL)) begin
        if (iomem_wstrb[0]) begin
          ctrl_en      <= iomem_wdata[CTRL_EN_BIT];
          ctrl_dir     <= iomem_wdata[CTRL_DIR_BIT];
          ctrl_counted <= iomem_wdata[CTRL_COUNTED_BIT];
        end
        ctrl_done <= 1'b0;
      end

      if (wr && (offset == REG_PERIOD)) begin
        period <= apply_wstrb(period, iomem_wdata, iomem_wstrb);
      end

      if (steps_wr) begin
        steps <= apply_wstrb(steps, iomem_wdata, iomem_wstrb);
      end else if (step && ctrl_counted) begin
        steps <= steps - 32'd1;
      end

      if (pos_wr) begin
        position <= apply_wstrb(position, iomem_wdata, iomem_wstrb);
      end else if (step) begin
        position <= ctrl_dir ? (position - 32'd1) : (position + 32'd1);
      end

      if (run_done) begin
        ctrl_en    <= 1'b0;
        ctrl_done  <= 1'b1;
        done_pulse <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quadrature_gen.sv
// tb_quadrature_gen
//   Scoreboard bench for quadrature_gen: every bus access pushes its expected
//   response, and a monitor pops and compares on each iomem_ready. Phase and
//   done_pulse outputs are compared cycle by cycle against hand-computed
//   sequences.
module tb_quadrature_gen;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic [31:0] iomem_rdata;
  logic        enc_a;
  logic        enc_b;
  logic        done_pulse;

  localparam logic [23:0] PAGE = 24'h03000A;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] mask;
    bit          chk;
    string       name;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  // {A,B} for forward phase index 0..3
  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  always #5 clk = ~clk;

  quadrature_gen dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .enc_a       (enc_a),
    .enc_b       (enc_b),
    .done_pulse  (done_pulse)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // One bus transaction; returns on the falling edge after the request edge.
  task automatic applyStimulus(input logic [7:0] off, input logic [3:0] wstrb,
                               input logic [31:0] wdata, input logic [31:0] exp,
                               input logic [31:0] mask, input bit chk, input string name);
    sb_t e;
    if (iomem_ready) @(negedge clk);
    e.exp = exp; e.mask = mask; e.chk = chk; e.name = name;
    sb.push_back(e);
    iomem_addr  = {PAGE, off};
    iomem_wstrb = wstrb;
    iomem_wdata = wdata;
    iomem_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
  endtask

  task automatic busWrite(input logic [7:0] off, input logic [31:0] data);
    applyStimulus(off, 4'hF, data, 32'h0, 32'h0, 1'b0, "write");
  endtask

  task automatic busRead(input logic [7:0] off, input logic [31:0] exp, input string name);
    applyStimulus(off, 4'h0, 32'h0, exp, 32'hFFFF_FFFF, 1'b1, name);
  endtask

  task automatic checkPhase(input string name, input logic [1:0] exp);
    checkOutput(name, {30'd0, enc_a, enc_b}, {30'd0, exp});
  endtask

  task automatic doReset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: pops one expected response per acknowledge.
  always @(negedge clk) begin
    if (iomem_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_ready actual=1 expected=0");
      end else begin
        sb_t e;
        e = sb.pop_front();
        if (e.chk) checkOutput(e.name, iomem_rdata & e.mask, e.exp & e.mask);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Reset state
    $display("[TB] reset values");
    checkPhase("reset_phase", 2'b00);
    checkOutput("reset_done_pulse", {31'd0, done_pulse}, 32'd0);
    busRead(8'h00, 32'h0, "reset_ctrl");
    busRead(8'h04, 32'd1600, "reset_period");
    busRead(8'h08, 32'h0, "reset_steps");
    busRead(8'h0C, 32'h0, "reset_position");

    // Forward continuous, PERIOD=4
    $display("[TB] forward continuous period 4");
    busWrite(8'h04, 32'd4);
    busWrite(8'h00, 32'h1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      checkPhase("fwd_phase", seq[(k / 4) % 4]);
    end
    busWrite(8'h00, 32'h0);
    busRead(8'h0C, 32'd10, "fwd_position");

    // Counted reverse run, PERIOD=3, STEPS=5
    $display("[TB] counted reverse run");
    doReset();
    busWrite(8'h04, 32'd3);
    busWrite(8'h08, 32'd5);
    busWrite(8'h00, 32'h7);
    for (int k = 1; k <= 20; k++) begin
      int s;
      @(negedge clk);
      s = (k / 3 > 5) ? 5 : k / 3;
      checkPhase("rev_phase", seq[(4 - (s % 4)) % 4]);
      checkOutput("rev_done_pulse", {31'd0, done_pulse}, (k == 15) ? 32'd1 : 32'd0);
    end
    applyStimulus(8'h00, 4'h0, 32'h0, 32'h100, 32'h101, 1'b1, "rev_ctrl_done");
    busRead(8'h08, 32'h0, "rev_steps");
    busRead(8'h0C, 32'hFFFF_FFFB, "rev_position");
    repeat (6) begin
      @(negedge clk);
      checkPhase("rev_hold", 2'b01);
    end
    busWrite(8'h00, 32'h0);
    busRead(8'h00, 32'h0, "ctrl_done_cleared");

    // PERIOD clamp and POSITION wrap
    $display("[TB] period clamp and wrap");
    doReset();
    busWrite(8'h0C, 32'hFFFF_FFFF);
    busWrite(8'h04, 32'd0);
    busWrite(8'h00, 32'h1);
    @(negedge clk);
    checkPhase("clamp_phase_k1", 2'b00);
    @(negedge clk);
    checkPhase("clamp_phase_k2", 2'b10);
    busWrite(8'h00, 32'h0);
    busRead(8'h0C, 32'h0, "wrap_position");
    busRead(8'h04, 32'h0, "clamp_period_raw");
    busWrite(8'h00, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checkPhase("clamp_run_phase", seq[(1 + k / 2) % 4]);
    end
    busWrite(8'h00, 32'h0);
    busRead(8'h0C, 32'd3, "clamp_position");

    // Byte strobes, unmapped offset, foreign page
    $display("[TB] byte strobes and decode");
    doReset();
    applyStimulus(8'h04, 4'b0010, 32'h0000_AB00, 32'h0, 32'h0, 1'b0, "byte_write");
    busRead(8'h04, 32'h0000_AB40, "byte_period");
    busRead(8'h10, 32'h0, "unmapped_read");
    @(negedge clk);
    iomem_addr  = 32'h0300_0B04;
    iomem_wstrb = 4'h0;
    iomem_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("nomatch_ready", {31'd0, iomem_ready}, 32'd0);
    end
    iomem_valid = 1'b0;

    // Reset asserted on the cycle a step is due
    $display("[TB] reset mid-run");
    busWrite(8'h04, 32'd4);
    busWrite(8'h00, 32'h1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checkPhase("mid_phase", seq[(k / 4) % 4]);
    end
    resetn = 1'b0;
    #1;
    checkPhase("async_reset_phase", 2'b00);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    busRead(8'h00, 32'h0, "post_reset_ctrl");
    busRead(8'h04, 32'd1600, "post_reset_period");
    busRead(8'h08, 32'h0, "post_reset_steps");
    busRead(8'h0C, 32'h0, "post_reset_position");
    repeat (10) begin
      @(negedge clk);
      checkPhase("post_reset_hold", 2'b00);
    end

    @(negedge clk);
    checkOutput("sb_drain", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
